// File: rtl/dtw_path_backtrace.sv
// ---------------------------------------------------------------------------
// dtw_path_backtrace
//   Reader side of the DTW path memory. Walks the 2-bit path codes backward
//   from the end cell (last_i,last_j) to (0,0) and streams every visited cell
//   on a valid/ready port, end cell first and (0,0) last.
//
// Ports
//   clk, nrst            clock; asynchronous active-low reset
//   start                begin a trace (only honoured while idle)
//   i_last_i, i_last_j   end cell, latched when start is accepted
//   busy, done, err      status: running / 1-cycle finish pulse / sticky error
//   mem_rd_en/addr/data  path memory read port, data one cycle after strobe
//   o_valid, o_ready     output cell handshake
//   o_i, o_j, o_last     current cell, o_last marks (0,0)
//   o_len                number of cells accepted so far
//
// Build option
//   DTW_BT_STATS_EN      adds o_ndiag / o_nup / o_nleft step counters
//
// State table
//   IDLE | waiting for start
//   RD   | read strobe for cell (ci,cj)
//   LAT  | capture path code, detect invalid interior code
//   EMIT | present cell, wait for o_ready, then step
//   FIN  | done pulse after (0,0) was accepted
//   ERR  | done pulse with err set
// ---------------------------------------------------------------------------
module dtw_path_backtrace #(
    parameter int IDX_W = 5,
    parameter int LEN_W = 6
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic [IDX_W-1:0]   i_last_i,
    input  logic [IDX_W-1:0]   i_last_j,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               mem_rd_en,
    output logic [2*IDX_W-1:0] mem_rd_addr,
    input  logic [1:0]         mem_rd_data,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [IDX_W-1:0]   o_i,
    output logic [IDX_W-1:0]   o_j,
    output logic               o_last,
    output logic [LEN_W-1:0]   o_len
`ifdef DTW_BT_STATS_EN
    ,
    output logic [LEN_W-1:0]   o_ndiag,
    output logic [LEN_W-1:0]   o_nup,
    output logic [LEN_W-1:0]   o_nleft
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LAT  = 3'd2,
        S_EMIT = 3'd3,
        S_FIN  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   ci_q, cj_q;
    logic [IDX_W-1:0]   ci_d, cj_d;
    logic [1:0]         code_q;
    logic               busy_q, done_q, err_q;
    logic               rd_en_q;
    logic [2*IDX_W-1:0] addr_q;
    logic               valid_q, last_q;
    logic [LEN_W-1:0]   len_q;
`ifdef DTW_BT_STATS_EN
    logic               step_diag, step_up, step_left;
    logic [LEN_W-1:0]   ndiag_q, nup_q, nleft_q;
`endif

    // Predecessor of the current cell. Boundary rows/columns force the step
    // regardless of the stored code.
    always_comb begin
        ci_d = ci_q;
        cj_d = cj_q;
`ifdef DTW_BT_STATS_EN
        step_diag = 1'b0;
        step_up   = 1'b0;
        step_left = 1'b0;
`endif
        if (ci_q == '0) begin
            cj_d = cj_q - 1'b1;
`ifdef DTW_BT_STATS_EN
            step_left = 1'b1;
`endif
        end else if (cj_q == '0) begin
            ci_d = ci_q - 1'b1;
`ifdef DTW_BT_STATS_EN
            step_up = 1'b1;
`endif
        end else begin
            case (code_q)
                2'b11: begin
                    ci_d = ci_q - 1'b1;
                    cj_d = cj_q - 1'b1;
`ifdef DTW_BT_STATS_EN
                    step_diag = 1'b1;
`endif
                end
                2'b10: begin
                    ci_d = ci_q - 1'b1;
`ifdef DTW_BT_STATS_EN
                    step_up = 1'b1;
`endif
                end
                2'b01: begin
                    cj_d = cj_q - 1'b1;
`ifdef DTW_BT_STATS_EN
                    step_left = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            ci_q    <= '0;
            cj_q    <= '0;
            code_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            len_q   <= '0;
`ifdef DTW_BT_STATS_EN
            ndiag_q <= '0;
            nup_q   <= '0;
            nleft_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ci_q    <= i_last_i;
                        cj_q    <= i_last_j;
                        err_q   <= 1'b0;
                        len_q   <= '0;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        addr_q  <= {i_last_i, i_last_j};
`ifdef DTW_BT_STATS_EN
                        ndiag_q <= '0;
                        nup_q   <= '0;
                        nleft_q <= '0;
`endif
                        state_q <= S_RD;
                    end
                end
                S_RD: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_LAT;
                end
                S_LAT: begin
                    code_q <= mem_rd_data;
                    if (ci_q != '0 && cj_q != '0 && mem_rd_data == 2'b00) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        valid_q <= 1'b1;
                        last_q  <= (ci_q == '0 && cj_q == '0);
                        state_q <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (o_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        len_q   <= (&len_q) ? len_q : len_q + 1'b1;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            ci_q    <= ci_d;
                            cj_q    <= cj_d;
                            rd_en_q <= 1'b1;
                            addr_q  <= {ci_d, cj_d};
`ifdef DTW_BT_STATS_EN
                            ndiag_q <= ndiag_q + LEN_W'(step_diag);
                            nup_q   <= nup_q + LEN_W'(step_up);
                            nleft_q <= nleft_q + LEN_W'(step_left);
`endif
                            state_q <= S_RD;
                        end
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = addr_q;
    assign o_valid     = valid_q;
    assign o_i         = ci_q;
    assign o_j         = cj_q;
    assign o_last      = last_q;
    assign o_len       = len_q;
`ifdef DTW_BT_STATS_EN
    assign o_ndiag     = ndiag_q;
    assign o_nup       = nup_q;
    assign o_nleft     = nleft_q;
`endif

endmodule
